// File: rtl/pipe_hazard_ctrl.sv
// Post-decode slot tracker: stall, bubble, flush and forwarding selects.
// Replaces the fixed EX/MEM/WB registers plus separate hazard/forward units.
module pipe_hazard_ctrl #(
  parameter int STAGES       = 4,
  parameter int REG_BITS     = 3,
  parameter int NSRC         = 2,
  parameter int CW           = 32,
  parameter int EARLY_STAGE  = 1,
  parameter int LATE_STAGE   = 2,
  parameter int FLUSH_STAGES = 2,
  parameter int CNTW         = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             advance,
  input  logic                             id_valid,
  input  logic [CW-1:0]                    id_ctrl,
  input  logic [REG_BITS-1:0]              id_dest,
  input  logic                             id_we,
  input  logic                             id_late,
  input  logic [NSRC*REG_BITS-1:0]         id_src,
  input  logic [NSRC-1:0]                  id_src_used,
  input  logic                             flush_req,
  input  logic                             cnt_clear,
  output logic                             stall,
  output logic [NSRC*$clog2(STAGES)-1:0]   fwd_sel,
  output logic [STAGES-1:0]                stg_valid,
  output logic [STAGES*CW-1:0]             stg_ctrl,
  output logic [STAGES*REG_BITS-1:0]       stg_dest,
  output logic [STAGES-1:0]                stg_we,
  output logic [CNTW-1:0]                  stall_cycles
);

  localparam int SW = $clog2(STAGES);

  logic [STAGES-1:0]                v_q, v_d;
  logic [STAGES-1:0]                we_q, we_d;
  logic [STAGES-1:0]                late_q, late_d;
  logic [STAGES-1:0][CW-1:0]        ctrl_q, ctrl_d;
  logic [STAGES-1:0][REG_BITS-1:0]  dest_q, dest_d;
  logic [NSRC-1:0][REG_BITS-1:0]    src_q, src_d;
  logic [NSRC-1:0]                  used_q, used_d;
  logic [CNTW-1:0]                  cnt_q, cnt_d;

  logic                             stall_c;
  logic                             hz;
  logic [NSRC-1:0][SW-1:0]          fwd_c;

  // Scan oldest to youngest so the youngest matching producer decides.
  always_comb begin
    stall_c = 1'b0;
    hz      = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      hz = 1'b0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        if (v_q[s] && we_q[s] &&
            dest_q[s] == id_src[j*REG_BITS +: REG_BITS]) begin
          hz = late_q[s] ? (s + 1 < LATE_STAGE)
                         : (s + 1 < EARLY_STAGE);
        end
      end
      if (id_src_used[j] && hz) stall_c = 1'b1;
    end
    stall_c = stall_c & id_valid & ~flush_req;
  end

  always_comb begin
    fwd_c = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        if (used_q[j] && v_q[k] && we_q[k] &&
            dest_q[k] == src_q[j]) begin
          fwd_c[j] = SW'(k);
        end
      end
    end
  end

  always_comb begin
    v_d    = v_q;
    we_d   = we_q;
    late_d = late_q;
    ctrl_d = ctrl_q;
    dest_d = dest_q;
    src_d  = src_q;
    used_d = used_q;
    if (advance) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        if (flush_req && k < FLUSH_STAGES) begin
          v_d[k]    = 1'b0;
          we_d[k]   = 1'b0;
          late_d[k] = 1'b0;
          ctrl_d[k] = '0;
          dest_d[k] = '0;
        end else begin
          v_d[k]    = v_q[k-1];
          we_d[k]   = we_q[k-1];
          late_d[k] = late_q[k-1];
          ctrl_d[k] = ctrl_q[k-1];
          dest_d[k] = dest_q[k-1];
        end
      end
      if (flush_req || stall_c) begin
        v_d[0]    = 1'b0;
        we_d[0]   = 1'b0;
        late_d[0] = 1'b0;
        ctrl_d[0] = '0;
        dest_d[0] = '0;
        src_d     = '0;
        used_d    = '0;
      end else begin
        v_d[0]    = id_valid;
        we_d[0]   = id_we & id_valid;
        late_d[0] = id_late & id_valid;
        ctrl_d[0] = id_ctrl;
        dest_d[0] = id_dest;
        src_d     = id_src;
        used_d    = id_src_used & {NSRC{id_valid}};
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (advance && stall_c && !flush_req && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      we_q   <= '0;
      late_q <= '0;
      ctrl_q <= '0;
      dest_q <= '0;
      src_q  <= '0;
      used_q <= '0;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      we_q   <= we_d;
      late_q <= late_d;
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      src_q  <= src_d;
      used_q <= used_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall        = stall_c;
  assign fwd_sel      = fwd_c;
  assign stg_valid    = v_q;
  assign stg_we       = we_q & v_q;
  assign stg_ctrl     = ctrl_q;
  assign stg_dest     = dest_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded random + directed bench for pipe_hazard_ctrl.
// Reference model keeps the pipeline as an array of instruction records.
module tb_pipe_hazard_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         advance = 1'b0;
  logic         id_valid = 1'b0;
  logic [31:0]  id_ctrl = '0;
  logic [2:0]   id_dest = '0;
  logic         id_we = 1'b0;
  logic         id_late = 1'b0;
  logic [5:0]   id_src = '0;
  logic [1:0]   id_src_used = '0;
  logic         flush_req = 1'b0;
  logic         cnt_clear = 1'b0;
  logic         stall;
  logic [3:0]   fwd_sel;
  logic [3:0]   stg_valid;
  logic [127:0] stg_ctrl;
  logic [11:0]  stg_dest;
  logic [3:0]   stg_we;
  logic [3:0]   stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_dest(id_dest),
    .id_we(id_we), .id_late(id_late), .id_src(id_src),
    .id_src_used(id_src_used), .flush_req(flush_req),
    .cnt_clear(cnt_clear), .stall(stall), .fwd_sel(fwd_sel),
    .stg_valid(stg_valid), .stg_ctrl(stg_ctrl), .stg_dest(stg_dest),
    .stg_we(stg_we), .stall_cycles(stall_cycles)
  );

  typedef struct {
    bit        v;
    bit        we;
    bit        late;
    bit [31:0] ctrl;
    bit [2:0]  dest;
  } slot_t;

  typedef struct {
    bit         stall;
    bit [3:0]   fwd;
    bit [3:0]   v;
    bit [3:0]   we;
    bit [127:0] ctrl;
    bit [11:0]  dest;
    bit [3:0]   cnt;
  } exp_t;

  slot_t    m[4], mn[4];
  bit [2:0] ms[2], msn[2];
  bit       mu[2], mun[2];
  int       mc, mcn;
  exp_t     sbq[$];
  int       n_chk = 0;
  int       n_pass = 0;
  bit       last_st;

  function automatic slot_t bub();
    slot_t b;
    b = '{default: 0};
    return b;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m[k]  = bub();
      mn[k] = bub();
    end
    for (int j = 0; j < 2; j++) begin
      ms[j] = 0; msn[j] = 0; mu[j] = 0; mun[j] = 0;
    end
    mc = 0;
    mcn = 0;
  endtask

  task automatic issue(input bit adv, input bit vld, input bit we,
                       input bit late, input bit [2:0] dst,
                       input bit [2:0] s0, input bit u0,
                       input bit [2:0] s1, input bit u1,
                       input bit fl, input bit clr);
    exp_t     e;
    bit       st;
    bit [31:0] cw;
    bit [2:0] src[2];
    bit       use_[2];
    slot_t    ent;
    @(posedge clk);
    #1;
    m = mn; ms = msn; mu = mun; mc = mcn;
    cw = vld ? $urandom : 32'd0;
    src[0] = s0; src[1] = s1;
    use_[0] = vld & u0; use_[1] = vld & u1;
    advance     = adv;
    id_valid    = vld;
    id_ctrl     = cw;
    id_dest     = vld ? dst : 3'd0;
    id_we       = we;
    id_late     = late;
    id_src      = {s1, s0};
    id_src_used = {use_[1], use_[0]};
    flush_req   = fl;
    cnt_clear   = clr;
    // Consumer needs producer at slot >= its ready stage once in EX.
    st = 0;
    if (vld && !fl) begin
      for (int j = 0; j < 2; j++) begin
        if (use_[j]) begin
          for (int s = 0; s < 4; s++) begin
            if (m[s].v && m[s].we && m[s].dest == src[j]) begin
              if (s + 1 < (m[s].late ? 2 : 1)) st = 1;
              break;
            end
          end
        end
      end
    end
    e.stall = st;
    e.fwd = 0;
    for (int j = 0; j < 2; j++) begin
      if (mu[j]) begin
        for (int k = 1; k < 4; k++) begin
          if (m[k].v && m[k].we && m[k].dest == ms[j]) begin
            e.fwd[j*2 +: 2] = 2'(k);
            break;
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      e.v[k]              = m[k].v;
      e.we[k]             = m[k].we & m[k].v;
      e.ctrl[k*32 +: 32]  = m[k].ctrl;
      e.dest[k*3 +: 3]    = m[k].dest;
    end
    e.cnt = 4'(mc);
    sbq.push_back(e);
    mn = m; msn = ms; mun = mu;
    if (adv) begin
      for (int k = 3; k >= 1; k--)
        mn[k] = (fl && k < 2) ? bub() : m[k-1];
      if (fl || st) begin
        mn[0] = bub();
        msn[0] = 0; msn[1] = 0; mun[0] = 0; mun[1] = 0;
      end else begin
        ent.v = vld; ent.we = we & vld; ent.late = late & vld;
        ent.ctrl = cw; ent.dest = vld ? dst : 3'd0;
        mn[0] = ent;
        msn = src; mun = use_;
      end
    end
    if (clr) mcn = 0;
    else if (adv && st) mcn = (mc < 15) ? mc + 1 : 15;
    else mcn = mc;
    last_st = st;
  endtask

  // Monitor: one expected record per cycle, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", 128'(stall), 128'(e.stall));
        chk("fwd_sel", 128'(fwd_sel), 128'(e.fwd));
        chk("stg_valid", 128'(stg_valid), 128'(e.v));
        chk("stg_we", 128'(stg_we), 128'(e.we));
        chk("stg_ctrl", stg_ctrl, e.ctrl);
        chk("stg_dest", 128'(stg_dest), 128'(e.dest));
        chk("stall_cycles", 128'(stall_cycles), 128'(e.cnt));
      end
    end
  end

  initial begin
    bit r_v, r_we, r_late, r_u0, r_u1, adv, fl, clr, take;
    bit [2:0] r_d, r_s0, r_s1;
    model_reset();
    #2 rst_n = 1'b0;
    #4;
    chk("reset_valid", 128'(stg_valid), 128'd0);
    chk("reset_cnt", 128'(stall_cycles), 128'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // ALU chain: ADD R1; ADD R2,R1; third reader of R1
    issue(1, 1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd2, 3'd1, 1, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd6, 3'd1, 1, 3'd0, 0, 0, 0);
    issue(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
    // Load-use
    issue(1, 1, 1, 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 0);
    issue(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
    // Shadowing: ADD R1; LDR R1; ADD R5,R1
    issue(1, 1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd5, 3'd0, 0, 3'd1, 1, 0, 0);
    issue(1, 1, 1, 0, 3'd5, 3'd0, 0, 3'd1, 1, 0, 0);
    issue(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
    // Flush with a pending load-use in ID
    issue(1, 1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd2, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 1, 3'd5, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd6, 3'd5, 1, 3'd0, 0, 1, 0);
    issue(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
    // Hold five cycles with a stall pending
    issue(1, 1, 1, 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0);
    repeat (5) issue(0, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 0);
    // Asynchronous reset mid-cycle
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(stg_valid), 128'd0);
    chk("async_rst_we", 128'(stg_we), 128'd0);
    chk("async_rst_cnt", 128'(stall_cycles), 128'd0);
    model_reset();
    advance = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic; ID holds its instruction while stalled
    take = 1;
    for (int i = 0; i < 400; i++) begin
      if (take) begin
        r_v = $urandom_range(0, 9) < 8;
        r_we = $urandom_range(0, 3) != 0;
        r_late = $urandom_range(0, 2) == 0;
        r_d = 3'($urandom_range(0, 3));
        r_s0 = 3'($urandom_range(0, 3));
        r_s1 = 3'($urandom_range(0, 3));
        r_u0 = $urandom_range(0, 3) != 0;
        r_u1 = $urandom_range(0, 1) != 0;
      end
      adv = $urandom_range(0, 9) < 8;
      fl = $urandom_range(0, 9) == 0;
      clr = adv && $urandom_range(0, 29) == 0;
      issue(adv, r_v, r_we, r_late, r_d, r_s0, r_u0, r_s1, r_u1, fl, clr);
      take = adv && !last_st;
    end

    // Saturation: 20 load-use stalls with a 4-bit counter
    issue(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      issue(1, 1, 1, 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0);
      issue(1, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 0);
      issue(1, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 0);
    end
    issue(1, 1, 1, 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0);
    issue(1, 1, 1, 0, 3'd4, 3'd3, 1, 3'd0, 0, 0, 1);
    issue(1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d records left expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the hard-wired EX/MEM/WB transition registers and the separate hazard and forwarding units in the LC-3b pipelined datapath.
- Tracks STAGES post-decode pipeline slots: control payload, destination, write-enable, result latency and sources of the EX slot.
- Generates the decode stall, bubbles, multi-stage flush and per-source forwarding selects for NSRC operands.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- STAGES, 4, tracked slots after ID; slot 0 = EX, slot STAGES-1 = WB.
- REG_BITS, 3, register index width.
- NSRC, 2, source operands per instruction.
- CW, 32, control-word payload width.
- EARLY_STAGE, 1, first slot holding an ALU/LEA result.
- LATE_STAGE, 2, first slot holding a load (late) result; must be >= EARLY_STAGE and < STAGES.
- FLUSH_STAGES, 2, number of youngest slots squashed on flush (ID entry plus FLUSH_STAGES-1 slots); range 1..STAGES.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  global pipeline load (all memories responded).
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  CW  decoded control word.
- id_dest  in  REG_BITS  destination register.
- id_we  in  1  instruction writes the regfile.
- id_late  in  1  result available only from LATE_STAGE (loads).
- id_src  in  NSRC*REG_BITS  source indices; operand j at [j*REG_BITS +: REG_BITS].
- id_src_used  in  NSRC  per-source valid.
- flush_req  in  1  redirect (taken branch/JMP/JSR/TRAP).
- cnt_clear  in  1  synchronous clear of stall_cycles.
- stall  out  1  ID must hold; bubble enters EX.
- fwd_sel  out  NSRC*$clog2(STAGES)  per EX source: 0 = register/operand latch, k = slot k.
- stg_valid  out  STAGES  per-slot valid.
- stg_ctrl  out  STAGES*CW  per-slot control word.
- stg_dest  out  STAGES*REG_BITS  per-slot destination.
- stg_we  out  STAGES  per-slot regfile write-enable, gated by valid.
- stall_cycles  out  CNTW  saturating stall count.

Behaviour:
- Reset (async, rst_n=0): all stg_valid/stg_we/stg_ctrl/stg_dest/EX sources = 0; stall_cycles = 0.
  - Outputs are combinational from this state: stall=0, fwd_sel=0.
- advance=0: every slot holds and the counter holds. flush_req is ignored; the requester keeps it high until advance.
- advance=1, no flush, no stall: slot k+1 <= slot k; slot 0 <= ID entry.
  - Slot valid = id_valid; slot we = id_we & id_valid.
  - EX source indices/used bits are captured in slot 0.
- Stall (combinational, computed only when id_valid and no flush_req):
  - For each used source j, find the youngest slot s with valid & we & dest == id_src[j].
  - Stall if (s+1) < LATE_STAGE when that slot is late, or (s+1) < EARLY_STAGE otherwise.
  - Only the youngest match counts; an older match shadowed by a younger one is irrelevant. R0 is a real register (no zero exclusion).
- advance=1 with stall: slots 1.. shift normally; slot 0 <= bubble (valid=0, we=0, ctrl=0, dest=0, sources unused); ID holds.
- advance=1 with flush_req:
  - slot 0 <= bubble.
  - Slots 1..FLUSH_STAGES-1 receive a bubble instead of their predecessor.
  - Slots >= FLUSH_STAGES shift normally.
  - Flush overrides stall; stall output is 0 while flush_req=1.
- fwd_sel[j]: youngest slot k in 1..STAGES-1 with valid & we & dest == EX src[j] & EX used[j], else 0.
  - The WB slot is included, since the regfile writes at the clock edge.
  - The stall rule guarantees the selected slot already holds its result.
- stall_cycles: +1 on each cycle with advance & stall & ~flush_req; saturates at 2^CNTW-1; cnt_clear wins over increment.
- Simultaneous bubble and shift are both applied in one edge; no extra latency. Decision-to-slot latency is 1 advance edge.
- rst_n asserted mid-operation squashes every in-flight slot immediately; no partial state survives.

Test Plan:
- ALU dependency: ADD R1 then ADD R2,R1 with advance every cycle → no stall; consumer in EX sees fwd_sel[0]=1.
  - One cycle later, an independent third instruction sourcing R1 sees fwd_sel=2.
- Load-use: LDR R3 (late) then ADD R4,R3 → stall=1 for exactly one advance and slot 0 is a bubble.
  - The consumer then reaches EX with fwd_sel[0]=2; stall_cycles=1.
- Shadowing: ADD R1; LDR R1; ADD R5,R1 → stall asserted because of the younger load.
  - After the stall, fwd_sel selects the load slot (2), not the ADD (3).
- Flush: FLUSH_STAGES=2, slots 0..3 valid, flush_req with advance → slots 0 and 1 invalid.
  - Old slots 1 and 2 land in slots 2 and 3; stall is 0 despite a pending dependency; counter is unchanged.
- Hold and reset: advance=0 for 5 cycles with a stall pending → slot contents and stall_cycles are unchanged.
  - Asserting rst_n=0 mid-cycle clears stg_valid to 0 without waiting for a clock edge.
- Saturation: CNTW=4, force 20 stalled advances → stall_cycles=15; cnt_clear together with a stall → 0.
